// File: rtl/rr_index_arbiter_if.sv
// Request/grant bus between requesters, the round-robin index arbiter and the
// downstream one-hot converter. Signal names are seen from the arbiter side.
interface rr_index_arbiter_if #(
    parameter int NUM_REQ = 16,
    parameter int IDX_W   = 4
);
    logic [NUM_REQ-1:0] req_i;
    logic               gnt_ready_i;
    logic               gnt_valid_o;
    logic [IDX_W-1:0]   gnt_idx_o;
    logic               busy_o;

    modport master (
        output req_i, gnt_ready_i,
        input  gnt_valid_o, gnt_idx_o, busy_o
    );

    modport slave (
        input  req_i, gnt_ready_i,
        output gnt_valid_o, gnt_idx_o, busy_o
    );
endinterface

// File: rtl/rr_index_arbiter.sv
// Round-robin arbiter: picks one requester fairly and holds its registered
// binary index with valid/ready until the consumer accepts it.
module rr_index_arbiter #(
    parameter int NUM_REQ = 16,
    parameter int IDX_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    rr_index_arbiter_if.slave bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    state_t           state_q;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] gnt_idx_q;
    logic             gnt_valid_q;

    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W-1:0] base_idx;
    logic [IDX_W-1:0] win_idx;
    logic             win_found;

    // On a transfer the search starts just past the accepted index, so the
    // same edge can issue the next grant.
    always_comb begin
        int                 cand;
        logic [NUM_REQ-1:0] req_shift;
        // NOTE: every combinational output gets a default first, so no path through the block infers a latch.
        cand      = 0;
        req_shift = '0;
        win_found = 1'b0;
        win_idx   = '0;
        ptr_d     = (gnt_idx_q == LAST_IDX) ? '0 : gnt_idx_q + IDX_W'(1);
        base_idx  = (state_q == GRANT) ? ptr_d : ptr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(base_idx) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            req_shift = bus.req_i >> cand;
            if (!win_found && req_shift[0]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
    end

    // NOTE: non-blocking assignments here so every register samples the pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        state_q     <= GRANT;
                        gnt_idx_q   <= win_idx;
                        gnt_valid_q <= 1'b1;
                    end
                end
                GRANT: begin
                    // Without ready the grant is frozen; request changes are ignored.
                    if (bus.gnt_ready_i) begin
                        ptr_q <= ptr_d;
                        if (win_found) begin
                            gnt_idx_q <= win_idx;
                        end else begin
                            state_q     <= IDLE;
                            gnt_valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    gnt_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt_valid_o = gnt_valid_q;
    assign bus.gnt_idx_o   = gnt_idx_q;
    assign bus.busy_o      = gnt_valid_q;
endmodule

// File: tb/tb_rr_index_arbiter.sv
// Self-checking bench for rr_index_arbiter: directed vector table, reset and
// rotation sequences, and a scoreboarded random run at NUM_REQ=16 and 10.
module tb_rr_index_arbiter;
    typedef struct {
        logic [15:0] req;
        logic        ready;
        logic        exp_valid;
        logic [3:0]  exp_idx;
    } vec_t;

    logic clk;
    logic reset;

    rr_index_arbiter_if #(.NUM_REQ(16), .IDX_W(4)) if16 ();
    rr_index_arbiter_if #(.NUM_REQ(10), .IDX_W(4)) if10 ();

    rr_index_arbiter #(.NUM_REQ(16), .IDX_W(4)) u_dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (if16)
    );

    rr_index_arbiter #(.NUM_REQ(10), .IDX_W(4)) u_dut10 (
        .clk   (clk),
        .reset (reset),
        .bus   (if10)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vq[$];

    int m_valid;
    int m_idx;
    int m_ptr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset            = 1'b1;
        if16.req_i       = '0;
        if16.gnt_ready_i = 1'b0;
        if10.req_i       = '0;
        if10.gnt_ready_i = 1'b0;
        #2;
        reset            = 1'b0;
        m_valid = 0;
        m_idx   = 0;
        m_ptr   = 0;
    endtask

    task automatic add(input logic [15:0] req, input logic ready, input logic v, input logic [3:0] idx);
        vec_t e;
        e.req = req; e.ready = ready; e.exp_valid = v; e.exp_idx = idx;
        vq.push_back(e);
    endtask

    function automatic int rr_pick(input logic [15:0] req, input int base, input int n);
        for (int i = 0; i < n; i++) begin
            int k;
            k = (base + i) % n;
            if (((req >> k) & 16'd1) != 16'd0) return k;
        end
        return -1;
    endfunction

    // Reference behaviour of one clock edge for an n-requester arbiter.
    task automatic model_step(input logic [15:0] req, input logic ready, input int n);
        int p;
        if (m_valid == 0) begin
            p = rr_pick(req, m_ptr, n);
            if (p >= 0) begin
                m_valid = 1;
                m_idx   = p;
            end
        end else if (ready) begin
            m_ptr = (m_idx == n - 1) ? 0 : m_idx + 1;
            p = rr_pick(req, m_ptr, n);
            if (p >= 0) m_idx = p;
            else        m_valid = 0;
        end
    endtask

    function automatic logic [15:0] onehot(input logic [3:0] idx);
        logic [15:0] one;
        one = 16'd1;
        return one << idx;
    endfunction

    initial begin
        logic [15:0] r16;
        logic [9:0]  r10;

        // Reset state
        reset            = 1'b1;
        if16.req_i       = 16'h0010;
        if16.gnt_ready_i = 1'b0;
        if10.req_i       = '0;
        if10.gnt_ready_i = 1'b0;
        step();
        check("reset_valid", 32'(if16.gnt_valid_o), 32'd0);
        check("reset_idx",   32'(if16.gnt_idx_o),   32'd0);
        check("reset_busy",  32'(if16.busy_o),      32'd0);

        // Reset mid-grant clears outputs without a clock edge
        reset = 1'b0;
        step();
        check("mid_first_grant", 32'(if16.gnt_idx_o),   32'd4);
        check("mid_first_valid", 32'(if16.gnt_valid_o), 32'd1);
        step();
        check("mid_hold_idx",    32'(if16.gnt_idx_o),   32'd4);
        #2;
        reset = 1'b1;
        #1;
        check("mid_async_valid", 32'(if16.gnt_valid_o), 32'd0);
        check("mid_async_idx",   32'(if16.gnt_idx_o),   32'd0);
        check("mid_async_busy",  32'(if16.busy_o),      32'd0);
        #1;
        reset = 1'b0;
        step();
        check("post_reset_idx",   32'(if16.gnt_idx_o),   32'd4);
        check("post_reset_valid", 32'(if16.gnt_valid_o), 32'd1);

        // Rotation with all requesters active
        do_reset();
        if16.req_i       = 16'hFFFF;
        if16.gnt_ready_i = 1'b1;
        for (int c = 0; c < 18; c++) begin
            step();
            check($sformatf("rot_idx_%0d", c), 32'(if16.gnt_idx_o),   32'(c % 16));
            check($sformatf("rot_val_%0d", c), 32'(if16.gnt_valid_o), 32'd1);
        end

        // Directed table: backpressure, wrap, idle return, single requester
        add(16'h0028, 1'b0, 1'b1, 4'd3);
        add(16'h0028, 1'b0, 1'b1, 4'd3);
        add(16'h0020, 1'b0, 1'b1, 4'd3);
        add(16'h0020, 1'b0, 1'b1, 4'd3);
        add(16'h0028, 1'b0, 1'b1, 4'd3);
        add(16'h0028, 1'b1, 1'b1, 4'd5);
        add(16'h0028, 1'b0, 1'b1, 4'd5);
        add(16'h4000, 1'b1, 1'b1, 4'd14);
        add(16'h8001, 1'b1, 1'b1, 4'd15);
        add(16'h8001, 1'b1, 1'b1, 4'd0);
        add(16'h8001, 1'b1, 1'b1, 4'd15);
        add(16'h0000, 1'b1, 1'b0, 4'd15);
        add(16'h0000, 1'b1, 1'b0, 4'd15);
        add(16'h0100, 1'b1, 1'b1, 4'd8);
        add(16'h0000, 1'b1, 1'b0, 4'd8);
        add(16'h0000, 1'b1, 1'b0, 4'd8);
        add(16'h0003, 1'b1, 1'b1, 4'd0);
        add(16'h0003, 1'b1, 1'b1, 4'd1);
        add(16'h0003, 1'b0, 1'b1, 4'd1);
        add(16'h0000, 1'b1, 1'b0, 4'd1);
        add(16'h0040, 1'b1, 1'b1, 4'd6);
        add(16'h0040, 1'b1, 1'b1, 4'd6);
        add(16'h0040, 1'b1, 1'b1, 4'd6);

        do_reset();
        foreach (vq[i]) begin
            if16.req_i       = vq[i].req;
            if16.gnt_ready_i = vq[i].ready;
            step();
            check($sformatf("vec%0d_valid", i), 32'(if16.gnt_valid_o), 32'(vq[i].exp_valid));
            check($sformatf("vec%0d_idx",   i), 32'(if16.gnt_idx_o),   32'(vq[i].exp_idx));
            check($sformatf("vec%0d_busy",  i), 32'(if16.busy_o),      32'(vq[i].exp_valid));
        end

        // Random non-zero requests, 16 requesters, chained with the converter
        do_reset();
        for (int c = 0; c < 32; c++) begin
            r16 = 16'($urandom_range(1, 65535));
            if16.req_i       = r16;
            if16.gnt_ready_i = 1'b1;
            step();
            model_step(r16, 1'b1, 16);
            check($sformatf("rnd16_valid_%0d", c), 32'(if16.gnt_valid_o), 32'(m_valid));
            check($sformatf("rnd16_idx_%0d", c),   32'(if16.gnt_idx_o),   32'(m_idx));
            check($sformatf("rnd16_hit_%0d", c),
                  32'((onehot(if16.gnt_idx_o) & r16) != 16'd0), 32'd1);
        end

        // Random non-zero requests, 10 requesters
        do_reset();
        for (int c = 0; c < 32; c++) begin
            r10 = 10'($urandom_range(1, 1023));
            if10.req_i       = r10;
            if10.gnt_ready_i = 1'b1;
            step();
            model_step({6'd0, r10}, 1'b1, 10);
            check($sformatf("rnd10_valid_%0d", c), 32'(if10.gnt_valid_o), 32'(m_valid));
            check($sformatf("rnd10_idx_%0d", c),   32'(if10.gnt_idx_o),   32'(m_idx));
            check($sformatf("rnd10_range_%0d", c), 32'(if10.gnt_idx_o < 4'd10), 32'd1);
            check($sformatf("rnd10_hit_%0d", c),
                  32'((onehot(if10.gnt_idx_o) & {6'd0, r10}) != 16'd0), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rr_index_arbiter.md
Name: rr_index_arbiter

Overview:
- Round-robin arbiter that sits directly upstream of the binary-to-one-hot converter.
- Samples a request vector and selects one requester fairly.
- Presents the winner as a registered binary index with a valid/ready handshake; the downstream converter expands that index back to one-hot.
- Holds each grant stable until the consumer accepts it.

Parameters:
- NUM_REQ, 16, number of requesters (2..16); valid index range is 0..NUM_REQ-1.
- IDX_W, 4, width of the grant index; must equal $clog2(NUM_REQ).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req_i  input  NUM_REQ  request vector; bit k high means requester k wants service.
- gnt_ready_i  input  1  consumer accepts the current grant this cycle.
- gnt_valid_o  output  1  gnt_idx_o holds a valid grant.
- gnt_idx_o  output  IDX_W  binary index of the granted requester.
- busy_o  output  1  high while in state GRANT (equal to gnt_valid_o).

Behaviour:
- Clock and reset (decided): one clock, clk. reset is asynchronous and active-high.
- Reset values: gnt_valid_o=0, gnt_idx_o=0, busy_o=0, internal priority pointer ptr=0, state=IDLE.
  - Reset clears all of these immediately, without waiting for a clock edge, including mid-grant.
  - After reset deasserts, the first edge may arbitrate.
- States: IDLE (no grant outstanding) and GRANT (grant outstanding, outputs frozen).
- Search rule: scan req_i starting at index ptr, upward, wrapping from NUM_REQ-1 to 0; the first set bit wins.
- IDLE -> GRANT: at a rising edge with any req_i bit set.
  - gnt_idx_o <= winner; gnt_valid_o <= 1.
  - Latency: request sampled at edge N gives valid high after edge N.
- IDLE -> IDLE: req_i all zero; outputs unchanged, gnt_valid_o stays 0.
- GRANT with gnt_ready_i=0: hold. gnt_idx_o and gnt_valid_o are stable.
  - Changes on req_i are ignored, including a drop of the granted requester's own bit. There is no retraction.
- GRANT with gnt_ready_i=1 (transfer at that edge):
  - ptr <= (gnt_idx_o == NUM_REQ-1) ? 0 : gnt_idx_o+1.
  - In the same edge, arbitrate req_i using this new ptr value.
  - If any bit is set: stay in GRANT with the new index (back-to-back, one grant per cycle).
  - Otherwise: go to IDLE and drive gnt_valid_o <= 0. gnt_idx_o keeps its last value.
- Fairness: a continuously requesting requester is granted within NUM_REQ transfers.
  - Only one requester active: it wins every transfer.
- gnt_ready_i in IDLE: ignored, no pointer update.
- Width rules:
  - gnt_idx_o is never >= NUM_REQ.
  - Pointer wrap is explicit compare-and-reset, not modulo 2^IDX_W, so non-power-of-two NUM_REQ (e.g. 10) is correct.
- Simultaneous events: reset overrides everything. A transfer and new requests in the same cycle follow the GRANT-with-ready rule.
- No combinational path from req_i or gnt_ready_i to any output.

Test Plan:
- Reset mid-grant: req_i=16'h0010, ready low so the grant holds, then pulse reset between edges -> gnt_valid_o=0 and gnt_idx_o=0 immediately. After release, first edge grants index 4.
- Rotation: req_i=16'hFFFF, gnt_ready_i=1 held for 18 cycles -> gnt_idx_o sequence 0,1,...,15,0,1 with gnt_valid_o=1 every cycle.
- Backpressure hold: req_i=16'h0028, gnt_ready_i=0 for 5 cycles -> gnt_idx_o=3 stable.
  - Also drop req_i bit 3 during the hold -> grant still 3.
  - Then ready=1 for one cycle -> next gnt_idx_o=5.
- Wrap with sparse requests: after a grant of 14, req_i=16'h8001, ready=1 -> next grants 15, then 0, then 15.
- Idle return: single req_i=16'h0100 for one cycle, ready=1 -> gnt_idx_o=8 valid for exactly one cycle, then gnt_valid_o=0 and gnt_idx_o stays 8.
- Chained with the converter: NUM_REQ=16, 32 random non-zero req_i vectors, ready=1. On every valid cycle, the converter output must equal 1<<gnt_idx_o and must AND non-zero with the sampled req_i. Repeat with NUM_REQ=10 and confirm gnt_idx_o<10 always.
